// File: rtl/mmio_io_ctrl.sv
// Memory-mapped LED / seven-segment / key / switch / cycle-counter block for the multicycle RISC-V SoC.
// Define IO_DEBOUNCE_EN to add per-bit debounce counters; otherwise inputs are synchronised and delayed one cycle.
module mmio_io_ctrl #(
    parameter int LED_W      = 10,
    parameter int SW_W       = 10,
    parameter int KEY_W      = 4,
    parameter int HEX_DIGITS = 6,
    parameter int DEB_CYCLES = 250000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sel,
    input  logic [7:0]              addr,
    input  logic [31:0]             writedata,
    input  logic                    memwrite,
    output logic [31:0]             readdata,
    input  logic [KEY_W-1:0]        KEY,
    input  logic [SW_W-1:0]         SW,
    output logic [LED_W-1:0]        LEDR,
    output logic [7*HEX_DIGITS-1:0] HEX
);

    localparam logic [5:0] OFF_LEDS   = 6'h01;
    localparam logic [5:0] OFF_HEX    = 6'h02;
    localparam logic [5:0] OFF_BLANK  = 6'h03;
    localparam logic [5:0] OFF_KEY    = 6'h04;
    localparam logic [5:0] OFF_KEYEV  = 6'h05;
    localparam logic [5:0] OFF_SW     = 6'h08;
    localparam logic [5:0] OFF_CYCLES = 6'h0C;
    localparam int         IN_W       = KEY_W + SW_W;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [5:0]              word;
    logic                    wr_en;
    logic [KEY_W-1:0]        key_p0, key_p1;
    logic [SW_W-1:0]         sw_p0, sw_p1;
    logic [IN_W-1:0]         in_sync;
    logic [IN_W-1:0]         deb_p2;
    logic [IN_W-1:0]         deb_d;
    logic [KEY_W-1:0]        key_deb;
    logic [SW_W-1:0]         sw_deb;
    logic [KEY_W-1:0]        key_rise;
    logic [KEY_W-1:0]        keyev_clr;
    logic [LED_W-1:0]        led_q;
    logic [4*HEX_DIGITS-1:0] hex_q;
    logic [HEX_DIGITS-1:0]   blank_q;
    logic [KEY_W-1:0]        keyev_q;
    logic [31:0]             cycles_q;
    logic                    unused_ok;

    assign word  = addr[7:2];
    assign wr_en = sel & memwrite;

    // Stage p0/p1: two-flop synchronisers, parked at the idle pin level in reset
    always_ff @(posedge clk) begin
        if (reset) begin
            key_p0 <= '1;
            key_p1 <= '1;
            sw_p0  <= '0;
            sw_p1  <= '0;
        end else begin
            key_p0 <= KEY;
            key_p1 <= key_p0;
            sw_p0  <= SW;
            sw_p1  <= sw_p0;
        end
    end

    // Keys are carried as 1 = pressed from here on
    assign in_sync = {sw_p1, ~key_p1};

`ifdef IO_DEBOUNCE_EN
    localparam int                CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [IN_W-1:0][CNT_W-1:0] cnt_p2;
    logic [IN_W-1:0][CNT_W-1:0] cnt_d;

    always_comb begin
        deb_d = deb_p2;
        cnt_d = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (in_sync[i] != deb_p2[i]) begin
                if (cnt_p2[i] == CNT_LAST) begin
                    deb_d[i] = in_sync[i];
                end else begin
                    cnt_d[i] = cnt_p2[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p2 <= '0;
        end else begin
            cnt_p2 <= cnt_d;
        end
    end

    assign unused_ok = ^addr[1:0];
`else
    assign deb_d     = in_sync;
    assign unused_ok = ^{addr[1:0], 32'(DEB_CYCLES)};
`endif

    // Stage p2: debounced levels
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_p2 <= '0;
        end else begin
            deb_p2 <= deb_d;
        end
    end

    assign key_deb   = deb_p2[KEY_W-1:0];
    assign sw_deb    = deb_p2[IN_W-1:KEY_W];
    assign key_rise  = deb_d[KEY_W-1:0] & ~deb_p2[KEY_W-1:0];
    assign keyev_clr = (wr_en && word == OFF_KEYEV) ? writedata[KEY_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q    <= '0;
            hex_q    <= '0;
            blank_q  <= '1;
            keyev_q  <= '0;
            cycles_q <= '0;
        end else begin
            if (wr_en && word == OFF_LEDS)  led_q   <= writedata[LED_W-1:0];
            if (wr_en && word == OFF_HEX)   hex_q   <= writedata[4*HEX_DIGITS-1:0];
            if (wr_en && word == OFF_BLANK) blank_q <= writedata[HEX_DIGITS-1:0];
            // A press landing on a clearing write still sets the bit
            keyev_q  <= (keyev_q & ~keyev_clr) | key_rise;
            cycles_q <= (wr_en && word == OFF_CYCLES) ? writedata : cycles_q + 32'd1;
        end
    end

    always_comb begin
        readdata = '0;
        if (sel) begin
            case (word)
                OFF_LEDS:   readdata[LED_W-1:0]        = led_q;
                OFF_HEX:    readdata[4*HEX_DIGITS-1:0] = hex_q;
                OFF_BLANK:  readdata[HEX_DIGITS-1:0]   = blank_q;
                OFF_KEY:    readdata[KEY_W-1:0]        = key_deb;
                OFF_KEYEV:  readdata[KEY_W-1:0]        = keyev_q;
                OFF_SW:     readdata[SW_W-1:0]         = sw_deb;
                OFF_CYCLES: readdata                   = cycles_q;
                default:    readdata                   = '0;
            endcase
        end
    end

    assign LEDR = led_q;

    always_comb begin
        HEX = '1;
        for (int i = 0; i < HEX_DIGITS; i++) begin
            HEX[7*i +: 7] = blank_q[i] ? 7'h7F : seg7(hex_q[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl: directed register-map cases followed by randomized bus/pin traffic
// compared every cycle against a behavioural model of the register map and input latency.
`timescale 1ns/1ps
module tb_mmio_io_ctrl;

    localparam int LED_W      = 10;
    localparam int SW_W       = 10;
    localparam int KEY_W      = 4;
    localparam int HEX_DIGITS = 6;
    localparam int DEB        = 8;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 2 + DEB;
`else
    localparam int LAT = 3;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    sel = 1'b0;
    logic [7:0]              addr = 8'h00;
    logic [31:0]             writedata = 32'h0;
    logic                    memwrite = 1'b0;
    logic [31:0]             readdata;
    logic [KEY_W-1:0]        KEY = '1;
    logic [SW_W-1:0]         SW = '0;
    logic [LED_W-1:0]        LEDR;
    logic [7*HEX_DIGITS-1:0] HEX;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mmio_io_ctrl #(
        .LED_W(LED_W), .SW_W(SW_W), .KEY_W(KEY_W),
        .HEX_DIGITS(HEX_DIGITS), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr), .writedata(writedata),
        .memwrite(memwrite), .readdata(readdata), .KEY(KEY), .SW(SW),
        .LEDR(LEDR), .HEX(HEX)
    );

    // Behavioural model state
    logic [6:0]       seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [31:0]      m_led, m_hex, m_blank, m_keyev, m_cyc;
    logic [KEY_W-1:0] m_key, kh1, kh2;
    logic [SW_W-1:0]  m_sw, sh1, sh2;
    int               krun [KEY_W];
    int               srun [SW_W];

    function automatic logic [31:0] mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    task automatic model_step();
        logic [KEY_W-1:0] nk;
        logic [SW_W-1:0]  ns;
        logic [31:0]      clr;
        logic [7:0]       off;
        logic             wr;
        if (reset) begin
            m_led = 0; m_hex = 0; m_blank = mask(HEX_DIGITS); m_keyev = 0; m_cyc = 0;
            m_key = '0; m_sw = '0; kh1 = '0; kh2 = '0; sh1 = '0; sh2 = '0;
            for (int i = 0; i < KEY_W; i++) krun[i] = 0;
            for (int i = 0; i < SW_W; i++) srun[i] = 0;
            return;
        end
        nk = m_key;
        ns = m_sw;
        // kh2/sh2 hold the pin level sampled two edges ago, i.e. what leaves the synchroniser now
`ifdef IO_DEBOUNCE_EN
        for (int i = 0; i < KEY_W; i++) begin
            if (kh2[i] !== m_key[i]) begin
                krun[i]++;
                if (krun[i] == DEB) begin nk[i] = kh2[i]; krun[i] = 0; end
            end else krun[i] = 0;
        end
        for (int i = 0; i < SW_W; i++) begin
            if (sh2[i] !== m_sw[i]) begin
                srun[i]++;
                if (srun[i] == DEB) begin ns[i] = sh2[i]; srun[i] = 0; end
            end else srun[i] = 0;
        end
`else
        nk = kh2;
        ns = sh2;
`endif
        wr  = sel & memwrite;
        off = {addr[7:2], 2'b00};
        clr = (wr && off == 8'h14) ? (writedata & mask(KEY_W)) : 32'h0;
        m_keyev = (m_keyev & ~clr) | 32'(nk & ~m_key);
        m_cyc   = (wr && off == 8'h30) ? writedata : m_cyc + 32'd1;
        if (wr && off == 8'h04) m_led   = writedata & mask(LED_W);
        if (wr && off == 8'h08) m_hex   = writedata & mask(4 * HEX_DIGITS);
        if (wr && off == 8'h0C) m_blank = writedata & mask(HEX_DIGITS);
        m_key = nk;
        m_sw  = ns;
        kh2 = kh1; kh1 = ~KEY;
        sh2 = sh1; sh1 = SW;
    endtask

    function automatic logic [31:0] m_read(input logic s, input logic [7:0] a);
        if (!s) return 32'h0;
        case ({a[7:2], 2'b00})
            8'h04: return m_led;
            8'h08: return m_hex;
            8'h0C: return m_blank;
            8'h10: return 32'(m_key);
            8'h14: return m_keyev;
            8'h20: return 32'(m_sw);
            8'h30: return m_cyc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7*HEX_DIGITS-1:0] m_hexout();
        logic [7*HEX_DIGITS-1:0] r;
        logic [3:0] nib;
        for (int i = 0; i < HEX_DIGITS; i++) begin
            nib = 4'(m_hex >> (4 * i));
            r[7*i +: 7] = m_blank[i] ? 7'h7F : seg_tab[nib];
        end
        return r;
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            compare("readdata", 64'(readdata), 64'(m_read(sel, addr)));
            compare("LEDR", 64'(LEDR), 64'(m_led));
            compare("HEX", 64'(HEX), 64'(m_hexout()));
        end
    end

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        sel = 1'b1; memwrite = 1'b1; addr = a; writedata = d;
        @(posedge clk); #1;
        memwrite = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a);
        sel = 1'b1; memwrite = 1'b0; addr = a;
    endtask

    logic [7:0] addr_tab [10] = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h30, 8'h18, 8'h00, 8'h3C};

    initial begin
        int idx;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        bus_read(8'h30);
        @(negedge clk);
        compare("rst_cycles", 64'(readdata), 64'h0);
        compare("rst_ledr", 64'(LEDR), 64'h0);
        compare("rst_hex", 64'(HEX), 64'h3FF_FFFF_FFFF);
        addr = 8'h14;
        #1 compare("rst_keyev", 64'(readdata), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        bus_write(8'h04, 32'h3A5);
        bus_write(8'h08, 32'h123456);
        bus_write(8'h0C, 32'h0);
        bus_read(8'h08);
        @(negedge clk);
        compare("led_3a5", 64'(LEDR), 64'h3A5);
        compare("digit0_6", 64'(HEX[6:0]), 64'h02);
        compare("digit5_1", 64'(HEX[35 +: 7]), 64'h79);
        compare("hex_read", 64'(readdata), 64'h123456);

        @(posedge clk); #1;
        sel = 1'b0; memwrite = 1'b1; addr = 8'h04; writedata = 32'h0;
        @(posedge clk); #1;
        memwrite = 1'b0;
        @(negedge clk);
        compare("sel0_write_led", 64'(LEDR), 64'h3A5);
        bus_read(8'h18);
        #1 compare("unmapped_read", 64'(readdata), 64'h0);

        @(posedge clk); #1;
        SW = 10'h2C3;
        repeat (LAT + 1) @(posedge clk);
        #1;
        bus_write(8'h20, 32'hFFFF_FFFF);
        bus_read(8'h20);
        @(negedge clk);
        compare("sw_ro", 64'(readdata), 64'h2C3);

        @(posedge clk); #1;
        bus_write(8'h30, 32'hFFFF_FFFE);
        bus_read(8'h30);
        @(negedge clk);
        compare("cyc_fffffffe", 64'(readdata), 64'hFFFF_FFFE);
        @(negedge clk);
        compare("cyc_ffffffff", 64'(readdata), 64'hFFFF_FFFF);
        @(negedge clk);
        compare("cyc_wrap", 64'(readdata), 64'h0);

        @(posedge clk); #1;
`ifdef IO_DEBOUNCE_EN
        KEY[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 KEY[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
`endif
        KEY[1] = 1'b0;
        bus_read(8'h10);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        compare("key_before_lat", 64'(readdata), 64'h0);
        @(negedge clk);
        compare("key_pressed", 64'(readdata), 64'h2);
        addr = 8'h14;
        #1 compare("keyev_bit1", 64'(readdata), 64'h2);

        @(posedge clk); #1;
        KEY[0] = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        sel = 1'b1; memwrite = 1'b1; addr = 8'h14; writedata = 32'h3;
        @(posedge clk); #1;
        memwrite = 1'b0;
        @(negedge clk);
        compare("w1c_collision", 64'(readdata), 64'h1);
        @(posedge clk); #1;
        KEY = '1;

        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            sel       = ($urandom_range(0, 3) != 0);
            memwrite  = ($urandom_range(0, 2) == 0);
            idx       = $urandom_range(0, 9);
            addr      = ($urandom_range(0, 7) == 0) ? 8'($urandom) : (addr_tab[idx] | 8'($urandom_range(0, 3)));
            writedata = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                idx = $urandom_range(0, KEY_W - 1);
                KEY[idx] = ~KEY[idx];
            end
            if ($urandom_range(0, 15) == 0) begin
                idx = $urandom_range(0, SW_W - 1);
                SW[idx] = ~SW[idx];
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; memwrite = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_io_ctrl.md
# mmio_io_ctrl

Parametrised memory-mapped I/O controller for the multicycle RISC-V SoC. It replaces the ad-hoc LED/HEX/KEY/SW glue in the board top level with one block. The block decodes CPU accesses in the I/O window and drives LEDs and N seven-segment digits with per-digit blanking. It synchronises and optionally debounces keys and switches, latches key-press events in a write-1-to-clear register, and provides a free-running cycle counter.

## Interface
Parameters:
- LED_W, 10, number of LED outputs (1..32)
- SW_W, 10, number of switch inputs (1..32)
- KEY_W, 4, number of push-button inputs (1..32)
- HEX_DIGITS, 6, number of seven-segment digits (1..8)
- DEB_CYCLES, 250000, stable cycles required before a debounced input changes (>=1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, CPU clock domain
- reset  in  1  synchronous, active-high
- sel  in  1  CPU access targets the I/O window (addr[8] in SoC)
- addr  in  8  byte address within window, addr[1:0] ignored
- writedata  in  32  CPU store data
- memwrite  in  1  store strobe, sampled with sel at posedge clk
- readdata  out  32  combinational read data
- KEY  in  KEY_W  board buttons, asynchronous, active-low
- SW  in  SW_W  board switches, asynchronous, active-high
- LEDR  out  LED_W  LED drive
- HEX  out  7*HEX_DIGITS  segment drive, active-low, digit i at [7i+6:7i], segment order g..a

## Operation
Register map (word offsets, addr[7:0]):
- 0x04 LEDS RW: [LED_W-1:0]; drives LEDR
- 0x08 HEX RW: [4*HEX_DIGITS-1:0], nibble i = hex value of digit i
- 0x0C BLANK RW: [HEX_DIGITS-1:0]; bit i=1 forces digit i to 7'h7F (off)
- 0x10 KEY RO: debounced key level, 1 = pressed (inverted from pin)
- 0x14 KEYEV RW1C: bit set on debounced 0->1 press transition; write 1 clears, write 0 no effect
- 0x20 SW RO: debounced switch level
- 0x30 CYCLES RW: 32-bit free-running counter, +1 every clk, wraps 0xFFFF_FFFF->0
- Write occurs when sel & memwrite at posedge clk. Bits above register width are ignored on write and read as 0.
- Writes to RO or unmapped offsets are ignored. Reads of unmapped offsets, or with sel=0, return 0.
- Input path per bit: 2-flop synchroniser, then the debouncer (see Configuration), then the debounced register.
- The seven-segment decoder covers 0-F: standard DE-board patterns, A,b,C,d,E,F for 10-15.

## Timing
- Reset values: LEDR=0, HEX reg=0, BLANK=all 1s (HEX out all 7'h7F), KEYEV=0, CYCLES=0, debounced KEY=0, debounced SW=0, synchronisers at inactive level (KEY pins 1, SW 0), debounce counters 0.
- Reset asserted mid-debounce or mid-count clears all state on the same edge. No partial event is recorded.
- Write latency: the register updates at the write edge. LEDR/HEX outputs change in the same cycle as the register.
- Read latency: 0 cycles. readdata reflects register state for the current addr. A read in the cycle after a write returns the new value.
- Input latency: pin change to debounced register in 2 cycles plus the debounce delay. The KEYEV bit sets on the same edge as the debounced KEY rises.
- KEYEV simultaneous W1C and new press on the same bit: set wins (bit stays 1).
- CYCLES write and increment on the same edge: write wins; the counter holds the written value, then increments on the next edge.
- Held key: exactly one KEYEV set per press. No re-trigger until release and re-press.

## Configuration
- IO_DEBOUNCE_EN defined: each KEY/SW bit has a counter. While the synchronised value differs from the debounced value, the counter increments; any agreement resets it to 0. When the count reaches DEB_CYCLES, the debounced value takes the synchronised value and the counter clears. Total latency = 2 + DEB_CYCLES cycles.
- IO_DEBOUNCE_EN undefined: no counters are instantiated. The debounced register = synchroniser output delayed 1 cycle (latency 3 cycles). DEB_CYCLES is unused.

## Test plan
- Reset: assert reset 2 cycles -> LEDR=0, HEX all 7'h7F, read 0x30 = 0, read 0x14 = 0.
- LED/HEX: write 0x04=0x3A5, 0x08=0x123456, 0x0C=0 -> LEDR=0x3A5. Digit0 shows 6 (7'h02), digit5 shows 1 (7'h79). Read 0x08 = 0x123456.
- Debounce (IO_DEBOUNCE_EN, DEB_CYCLES=8): KEY[1] low with 3-cycle glitch, then held -> glitch ignored. Read 0x10 = 0x2 exactly 10 cycles after the stable low. 0x14 bit1=1.
- W1C collision: KEYEV=0x2 and a new KEY[0] press lands on the edge of a write 0x14=0x3 -> read 0x14 = 0x1.
- Counter: write 0x30=0xFFFF_FFFE -> reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0 on consecutive cycles.
- Decode: write with sel=0 to 0x04 -> LEDR unchanged. Read unmapped 0x18 -> 0. Write to 0x20 -> SW read unaffected.
